// File: rtl/multi_issue_queue_if.sv
// Fetch/execute-side bus of the multi-issue queue: bundle input, issue group output,
// flush and single-issue controls.
interface multi_issue_queue_if #(
  parameter int unsigned lanes_p          = 2,
  parameter int unsigned depth_p          = 8,
  parameter int unsigned instr_width_p    = 32,
  parameter int unsigned reg_addr_width_p = 5
);
  localparam int unsigned count_width_lp = $clog2(depth_p + 1);

  logic                                  flush_i;
  logic                                  single_issue_i;
  logic [lanes_p-1:0]                    v_i;
  logic                                  ready_o;
  logic [lanes_p*instr_width_p-1:0]      instr_i;
  logic [lanes_p*reg_addr_width_p-1:0]   rd_i;
  logic [lanes_p*reg_addr_width_p-1:0]   rs1_i;
  logic [lanes_p*reg_addr_width_p-1:0]   rs2_i;
  logic [lanes_p-1:0]                    write_rd_i;
  logic [lanes_p-1:0]                    read_rs1_i;
  logic [lanes_p-1:0]                    read_rs2_i;
  logic [lanes_p-1:0]                    ctrl_i;
  logic [lanes_p-1:0]                    issue_v_o;
  logic [lanes_p*instr_width_p-1:0]      issue_instr_o;
  logic                                  issue_ready_i;
  logic [count_width_lp-1:0]             count_o;

  modport master (
    output flush_i, single_issue_i, v_i, instr_i, rd_i, rs1_i, rs2_i,
           write_rd_i, read_rs1_i, read_rs2_i, ctrl_i, issue_ready_i,
    input  ready_o, issue_v_o, issue_instr_o, count_o
  );

  modport slave (
    input  flush_i, single_issue_i, v_i, instr_i, rd_i, rs1_i, rs2_i,
           write_rd_i, read_rs1_i, read_rs2_i, ctrl_i, issue_ready_i,
    output ready_o, issue_v_o, issue_instr_o, count_o
  );
endinterface

// File: rtl/multi_issue_queue.sv
// In-order issue queue: buffers predecoded bundles and issues up to lanes_p oldest
// entries per cycle, cutting the group at the first RAW/WAW hazard or after a ctrl op.
module multi_issue_queue #(
  parameter int unsigned lanes_p          = 2,
  parameter int unsigned depth_p          = 8,
  parameter int unsigned instr_width_p    = 32,
  parameter int unsigned reg_addr_width_p = 5
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  multi_issue_queue_if.slave q
);
  localparam int unsigned ptr_width_lp   = $clog2(depth_p);
  localparam int unsigned count_width_lp = $clog2(depth_p + 1);

  typedef logic [ptr_width_lp-1:0]   ptr_t;
  typedef logic [count_width_lp-1:0] cnt_t;

  typedef struct packed {
    logic [instr_width_p-1:0]    instr;
    logic [reg_addr_width_p-1:0] rd;
    logic [reg_addr_width_p-1:0] rs1;
    logic [reg_addr_width_p-1:0] rs2;
    logic                        write_rd;
    logic                        read_rs1;
    logic                        read_rs2;
    logic                        ctrl;
  } entry_t;

  entry_t             mem_q [depth_p];
  ptr_t               rptr_q, wptr_q;
  cnt_t               count_q;

  entry_t             in_e    [lanes_p];
  entry_t             head    [lanes_p];
  ptr_t               enq_off [lanes_p];
  logic               ready;
  logic               enq, deq;
  cnt_t               enq_n, deq_n;
  logic [lanes_p-1:0] issue_v;

  function automatic cnt_t popcnt(logic [lanes_p-1:0] m);
    cnt_t c;
    c = '0;
    for (int i = 0; i < int'(lanes_p); i++) c = c + cnt_t'(m[i]);
    return c;
  endfunction

  // Younger entry depends on (RAW) or overwrites (WAW) a live older destination.
  function automatic logic hazard(entry_t older, entry_t younger);
    logic live;
    live = older.write_rd && (older.rd != '0);
    return live && ((younger.read_rs1 && (younger.rs1 == older.rd)) ||
                    (younger.read_rs2 && (younger.rs2 == older.rd)) ||
                    (younger.write_rd && (younger.rd == older.rd)));
  endfunction

  // Unpack lanes and compute compacted write offsets for the valid ones.
  always_comb begin
    ptr_t off;
    off = '0;
    for (int l = 0; l < int'(lanes_p); l++) begin
      in_e[l].instr    = q.instr_i[l*instr_width_p +: instr_width_p];
      in_e[l].rd       = q.rd_i[l*reg_addr_width_p +: reg_addr_width_p];
      in_e[l].rs1      = q.rs1_i[l*reg_addr_width_p +: reg_addr_width_p];
      in_e[l].rs2      = q.rs2_i[l*reg_addr_width_p +: reg_addr_width_p];
      in_e[l].write_rd = q.write_rd_i[l];
      in_e[l].read_rs1 = q.read_rs1_i[l];
      in_e[l].read_rs2 = q.read_rs2_i[l];
      in_e[l].ctrl     = q.ctrl_i[l];
      enq_off[l]       = off;
      off              = off + ptr_t'(q.v_i[l]);
    end
  end

  // Space check uses start-of-cycle occupancy only.
  assign ready = (cnt_t'(depth_p) - count_q) >= cnt_t'(lanes_p);
  assign enq   = (|q.v_i) && ready && !q.flush_i;
  assign enq_n = enq ? popcnt(q.v_i) : '0;

  // Issue group formation from the queue head.
  always_comb begin
    logic ok;
    ok      = 1'b0;
    issue_v = '0;
    for (int k = 0; k < int'(lanes_p); k++) head[k] = mem_q[rptr_q + ptr_t'(k)];
    issue_v[0] = (count_q != '0) && !q.flush_i;
    for (int k = 1; k < int'(lanes_p); k++) begin
      ok = issue_v[k-1] && (cnt_t'(k) < count_q) && !head[k-1].ctrl && !q.single_issue_i;
      for (int j = 0; j < k; j++) begin
        if (hazard(head[j], head[k])) ok = 1'b0;
      end
      issue_v[k] = ok;
    end
  end

  assign deq   = q.issue_ready_i && (|issue_v) && !q.flush_i;
  assign deq_n = deq ? popcnt(issue_v) : '0;

  always_comb begin
    q.issue_instr_o = '0;
    for (int k = 0; k < int'(lanes_p); k++) begin
      q.issue_instr_o[k*instr_width_p +: instr_width_p] = issue_v[k] ? head[k].instr : '0;
    end
  end

  assign q.issue_v_o = issue_v;
  assign q.ready_o   = ready;
  assign q.count_o   = count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (q.flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wptr_q <= wptr_q + ptr_t'(enq_n);
      if (deq) rptr_q <= rptr_q + ptr_t'(deq_n);
      count_q <= count_q + enq_n - deq_n;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      for (int l = 0; l < int'(lanes_p); l++) begin
        if (q.v_i[l]) mem_q[wptr_q + enq_off[l]] <= in_e[l];
      end
    end
  end
endmodule

// File: tb/tb_multi_issue_queue.sv
// Bench for multi_issue_queue: queue-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_multi_issue_queue;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 32;
  localparam int unsigned RW    = 5;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic        wr, r1, r2, ctrl;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  multi_issue_queue_if #(.lanes_p(LANES), .depth_p(DEPTH), .instr_width_p(IW),
                         .reg_addr_width_p(RW)) bus ();

  multi_issue_queue #(.lanes_p(LANES), .depth_p(DEPTH), .instr_width_p(IW),
                      .reg_addr_width_p(RW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .q(bus)
  );

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(int id, int rd, int rs1, int rs2, bit wr, bit r1, bit r2, bit c);
    ent_t e;
    e.instr = 32'(id); e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
    e.wr = wr; e.r1 = r1; e.r2 = r2; e.ctrl = c;
    return e;
  endfunction
  function automatic ent_t alu(int id, int rd, int rs1, int rs2);
    return mk(id, rd, rs1, rs2, 1, 1, 1, 0);
  endfunction
  function automatic ent_t addi(int id, int rd, int rs1);
    return mk(id, rd, rs1, 0, 1, 1, 0, 0);
  endfunction
  function automatic ent_t br(int id, int rs1, int rs2);
    return mk(id, 0, rs1, rs2, 0, 1, 1, 1);
  endfunction
  function automatic ent_t jal(int id, int rd);
    return mk(id, rd, 0, 0, 1, 0, 0, 1);
  endfunction

  // Reference: hazard between an older and a younger instruction.
  function automatic bit haz(ent_t o, ent_t y);
    if (!o.wr || o.rd == 5'd0) return 0;
    return (y.r1 && y.rs1 == o.rd) || (y.r2 && y.rs2 == o.rd) || (y.wr && y.rd == o.rd);
  endfunction

  // Reference: how many head entries form this cycle's issue group.
  function automatic int exp_n();
    int n = 0;
    if (bus.flush_i) return 0;
    for (int k = 0; k < int'(LANES) && k < mq.size(); k++) begin
      bit hz = 0;
      if (k > 0 && bus.single_issue_i) break;
      for (int j = 0; j < k; j++) if (haz(mq[j], mq[k])) hz = 1;
      if (hz) break;
      n++;
      if (mq[k].ctrl) break;
    end
    return n;
  endfunction

  function automatic ent_t lane_ent(int l);
    return mk(int'(bus.instr_i[l*IW +: IW]), int'(bus.rd_i[l*RW +: RW]),
              int'(bus.rs1_i[l*RW +: RW]), int'(bus.rs2_i[l*RW +: RW]),
              bus.write_rd_i[l], bus.read_rs1_i[l], bus.read_rs2_i[l], bus.ctrl_i[l]);
  endfunction

  // Model state update on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else begin
      int n;
      bit rdy;
      n   = exp_n();
      rdy = (int'(DEPTH) - mq.size()) >= int'(LANES);
      if (bus.flush_i) mq.delete();
      else begin
        if (bus.issue_ready_i) repeat (n) void'(mq.pop_front());
        if (rdy) for (int l = 0; l < int'(LANES); l++) if (bus.v_i[l]) mq.push_back(lane_ent(l));
      end
    end
  end

  // Compare process: DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = exp_n();
      chk("count", bus.count_o, mq.size());
      chk("ready", bus.ready_o, (int'(DEPTH) - mq.size()) >= int'(LANES));
      chk("issue_v", bus.issue_v_o, (1 << n) - 1);
      for (int k = 0; k < n; k++) chk("issue_instr", bus.issue_instr_o[k*IW +: IW], mq[k].instr);
    end
  end

  task automatic clear_in();
    bus.v_i = '0; bus.instr_i = '0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.write_rd_i = '0; bus.read_rs1_i = '0; bus.read_rs2_i = '0; bus.ctrl_i = '0;
    bus.flush_i = 1'b0;
  endtask

  task automatic put(int l, ent_t e);
    bus.v_i[l] = 1'b1;
    bus.instr_i[l*IW +: IW] = e.instr;
    bus.rd_i[l*RW +: RW] = e.rd; bus.rs1_i[l*RW +: RW] = e.rs1; bus.rs2_i[l*RW +: RW] = e.rs2;
    bus.write_rd_i[l] = e.wr; bus.read_rs1_i[l] = e.r1; bus.read_rs2_i[l] = e.r2;
    bus.ctrl_i[l] = e.ctrl;
  endtask

  task automatic mid(); @(negedge clk); #1; endtask
  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic drain(bit single_chk);
    bit done = 0;
    clear_in();
    bus.issue_ready_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      mid();
      if (single_chk) chk("single_lane1", bus.issue_v_o[1], 0);
      if (bus.count_o == '0) done = 1;
      else cyc();
    end
    chk("drain_empty", bus.count_o, 0);
    cyc();
  endtask

  task automatic flush_seq(bit single);
    bus.single_issue_i = single;
    bus.issue_ready_i  = 1'b0;
    clear_in(); put(0, addi(60, 1, 0)); put(1, addi(61, 2, 0)); cyc();
    clear_in(); put(0, addi(62, 3, 0)); put(1, addi(63, 4, 0)); cyc();
    clear_in(); put(0, addi(64, 5, 0)); cyc();
    clear_in(); put(0, addi(90, 6, 0)); put(1, addi(91, 7, 0)); bus.flush_i = 1'b1;
    mid();
    chk("flush_issue_v", bus.issue_v_o, 0);
    chk("flush_count_before", bus.count_o, 5);
    cyc();
    clear_in(); mid();
    chk("flush_count_after", bus.count_o, 0);
    chk("flush_issue_v_after", bus.issue_v_o, 0);
    cyc();
    put(0, addi(92, 8, 0)); put(1, addi(93, 9, 0)); bus.issue_ready_i = 1'b1; cyc();
    clear_in(); mid();
    chk("post_flush_lane0", bus.issue_instr_o[IW-1:0], 92);
    chk("post_flush_v", bus.issue_v_o, single ? 1 : 3);
    cyc();
    drain(single);
    bus.single_issue_i = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int next_id;
    bit acc;
    clear_in();
    bus.single_issue_i = 1'b0;
    bus.issue_ready_i  = 1'b0;
    #3;
    chk("rst_count", bus.count_o, 0);
    chk("rst_issue_v", bus.issue_v_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    #9 rst_n = 1'b1;
    cyc();

    // Independent pair dual-issues one cycle after enqueue.
    put(0, alu(1, 1, 2, 3)); put(1, alu(2, 4, 5, 6)); bus.issue_ready_i = 1'b1; cyc();
    clear_in(); mid();
    chk("s1_v", bus.issue_v_o, 3);
    chk("s1_count", bus.count_o, 2);
    chk("s1_lane1", bus.issue_instr_o[2*IW-1:IW], 2);
    cyc(); mid();
    chk("s1_count_after", bus.count_o, 0);
    cyc();

    // RAW split.
    put(0, alu(3, 1, 2, 3)); put(1, alu(4, 5, 1, 4)); cyc();
    clear_in(); mid();
    chk("raw_v1", bus.issue_v_o, 1);
    chk("raw_lane0_1", bus.issue_instr_o[IW-1:0], 3);
    cyc(); mid();
    chk("raw_v2", bus.issue_v_o, 1);
    chk("raw_lane0_2", bus.issue_instr_o[IW-1:0], 4);
    cyc();

    // WAW split, then x0 destination pair dual-issues.
    put(0, addi(5, 7, 0)); put(1, addi(6, 7, 0)); cyc();
    clear_in(); mid();
    chk("waw_v1", bus.issue_v_o, 1);
    cyc(); mid();
    chk("waw_lane0_2", bus.issue_instr_o[IW-1:0], 6);
    cyc();
    put(0, addi(7, 0, 0)); put(1, alu(8, 3, 0, 0)); cyc();
    clear_in(); mid();
    chk("x0_v", bus.issue_v_o, 3);
    cyc();

    // Control ops end groups.
    put(0, br(9, 1, 2)); put(1, alu(10, 3, 4, 5)); cyc();
    clear_in(); mid();
    chk("beq_v", bus.issue_v_o, 1);
    chk("beq_lane0", bus.issue_instr_o[IW-1:0], 9);
    cyc(); mid();
    chk("after_beq_lane0", bus.issue_instr_o[IW-1:0], 10);
    cyc();
    put(0, alu(11, 3, 4, 5)); put(1, jal(12, 1)); cyc();
    clear_in(); mid();
    chk("jal_v", bus.issue_v_o, 3);
    chk("jal_lane1", bus.issue_instr_o[2*IW-1:IW], 12);
    cyc();

    // Fill to full with execute stalled.
    bus.issue_ready_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      clear_in(); put(0, addi(20 + 2*b, ((20 + 2*b) % 7) + 1, 0));
      put(1, addi(21 + 2*b, ((21 + 2*b) % 7) + 1, 0)); cyc();
    end
    clear_in(); mid();
    chk("full_count", bus.count_o, 8);
    chk("full_ready", bus.ready_o, 0);
    cyc();
    bus.issue_ready_i = 1'b1; cyc();
    bus.issue_ready_i = 1'b0; put(0, addi(28, 1, 0)); cyc();
    clear_in(); mid();
    chk("c7_count", bus.count_o, 7);
    chk("c7_ready", bus.ready_o, 0);
    cyc();

    // Release with a bundle held pending; stream wraps the write pointer.
    bus.issue_ready_i = 1'b1;
    next_id = 30;
    for (int i = 0; i < 30 && next_id < 46; i++) begin
      clear_in();
      put(0, alu(next_id, ((next_id * 3) % 5) + 1, ((next_id * 7) % 5) + 1, 0));
      put(1, alu(next_id + 1, ((next_id * 3 + 3) % 5) + 1, ((next_id * 7 + 7) % 5) + 1, 0));
      mid();
      acc = bus.ready_o;
      cyc();
      if (acc) next_id += 2;
    end
    chk("stream_all_accepted", next_id, 46);
    drain(0);

    flush_seq(0);
    flush_seq(1);

    // Asynchronous reset mid-operation.
    put(0, addi(100, 1, 0)); put(1, addi(101, 2, 0)); bus.issue_ready_i = 1'b0; cyc();
    clear_in(); mid();
    rst_n = 1'b0; #1;
    chk("arst_count", bus.count_o, 0);
    chk("arst_issue_v", bus.issue_v_o, 0);
    chk("arst_ready", bus.ready_o, 1);
    #1 rst_n = 1'b1;
    cyc(); mid();
    chk("arst_count_after", bus.count_o, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
